// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types, widths and default coefficient table for the FIR MAC sequencer
// Purpose: FSM state type, product/accumulator widths and the constant coefficient table
//          used when coefficients are not software-writable.
// Ports:   none (package).
package filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } filter_state_e;

   localparam int PROD_W    = 32;
   localparam int ACC_W     = 41;
   localparam int ROM_DEPTH = 64;
   localparam int ROM_AW    = 6;

   // Entry k is the coefficient applied to the sample k positions older than the newest one.
   localparam logic signed [15:0] FILTER_COEF_ROM [ROM_DEPTH] = '{
      16'sh8000,  16'sd1200, -16'sd900,   16'sd700,   16'sd512,  -16'sd300,   16'sd250,   16'sd100,
     -16'sd64,    16'sd33,    16'sd17,   -16'sd8,     16'sd4,     16'sd2,    -16'sd1,     16'sd1,
      16'sd3000, -16'sd2500,  16'sd2000, -16'sd1500,  16'sd1000, -16'sd500,   16'sd250,  -16'sd125,
      16'sd32767, 16'sd16384, 16'sd8192,  16'sd4096,  16'sd2048,  16'sd1024,  16'sd512,   16'sd256,
     -16'sd7,     16'sd11,   -16'sd13,    16'sd17,   -16'sd19,    16'sd23,   -16'sd29,    16'sd31,
      16'sd128,   16'sd64,    16'sd32,    16'sd16,    16'sd8,     16'sd4,     16'sd2,     16'sd1,
     -16'sd1000,  16'sd900,  -16'sd800,   16'sd700,  -16'sd600,   16'sd500,  -16'sd400,   16'sd300,
      16'sd5,     16'sd10,    16'sd15,    16'sd20,    16'sd25,    16'sd30,    16'sd35,    16'sd40
   };

endpackage

// File: rtl/filter_delay_line.sv
// rtl/filter_delay_line.sv - circular sample delay line with one write port and one age-indexed read port
// Purpose: holds the last NTAPS accepted samples; reads are addressed by age (0 = newest).
// Ports:   clk_i clock, clr_i synchronous clear (pointer and all entries to zero),
//          wr_en_i/wr_data_i write newest sample, rd_age_i age to read, rd_data_o sample read.
module filter_delay_line #(
   parameter int NTAPS = 16,
   parameter int DW    = 16
) (
   input  logic                       clk_i,
   input  logic                       clr_i,
   input  logic                       wr_en_i,
   input  logic signed [DW-1:0]       wr_data_i,
   input  logic [$clog2(NTAPS)-1:0]   rd_age_i,
   output logic signed [DW-1:0]       rd_data_o
);

   localparam int AW = $clog2(NTAPS);

   logic signed [DW-1:0] mem_q [NTAPS];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_addr;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
         wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
   end

   // The pointer has already moved past the newest entry, hence the extra -1; wraps mod NTAPS.
   assign rd_addr   = wr_ptr_q - AW'(1) - rd_age_i;
   assign rd_data_o = mem_q[rd_addr];

endmodule

// File: rtl/filter_mac_sequencer.sv
// rtl/filter_mac_sequencer.sv - FIR tap sequencer feeding an external 41-bit multiply-accumulate
// Purpose: accepts one sample per NTAPS+3 cycles, walks all taps and streams registered
//          products to a downstream accumulator, then pulses sum_valid.
// Ports:   clk, rstb (sync, active high); sample_valid/sample_data/sample_ready input handshake;
//          coef_we/coef_addr/coef_data coefficient writes (only with FILTER_SEQ_COEF_WR_EN);
//          acc_enable/acc_load/acc_d accumulator controls and product; sum_valid completion pulse.
// Config:  FILTER_SEQ_COEF_WR_EN - writable coefficient register file instead of FILTER_COEF_ROM.
module filter_mac_sequencer
   import filter_pkg::*;
#(
   parameter int NTAPS = 16,
   parameter int DW    = 16,
   parameter int CW    = 16
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic                       sample_valid,
   input  logic [DW-1:0]              sample_data,
   output logic                       sample_ready,
`ifdef FILTER_SEQ_COEF_WR_EN
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic [CW-1:0]              coef_data,
`endif
   output logic                       acc_enable,
   output logic                       acc_load,
   output logic signed [PROD_W-1:0]   acc_d,
   output logic                       sum_valid
);

   localparam int AW = $clog2(NTAPS);
   localparam logic [AW-1:0] TAP_LAST = AW'(NTAPS - 1);

   filter_state_e            state_q, state_d;
   logic [AW-1:0]            tap_q, tap_d;
   logic                     acc_enable_q, acc_enable_d;
   logic                     acc_load_q, acc_load_d;
   logic signed [PROD_W-1:0] acc_d_q, acc_d_d;

   logic                     accept;
   logic signed [DW-1:0]     tap_sample;
   logic signed [CW-1:0]     tap_coef;
   logic signed [PROD_W-1:0] tap_prod;

   assign accept = sample_valid && (state_q == ST_IDLE);

   filter_delay_line #(
      .NTAPS (NTAPS),
      .DW    (DW)
   ) u_delay_line (
      .clk_i     (clk),
      .clr_i     (rstb),
      .wr_en_i   (accept),
      .wr_data_i (sample_data),
      .rd_age_i  (tap_q),
      .rd_data_o (tap_sample)
   );

`ifdef FILTER_SEQ_COEF_WR_EN
   logic signed [CW-1:0] coef_q [NTAPS];

   // Writes outside IDLE are dropped so the taps of an in-flight sample never change.
   always_ff @(posedge clk) begin
      if (rstb) begin
         for (int i = 0; i < NTAPS; i++) begin
            coef_q[i] <= '0;
         end
      end else if (coef_we && (state_q == ST_IDLE)) begin
         coef_q[coef_addr] <= coef_data;
      end
   end

   assign tap_coef = coef_q[tap_q];
`else
   logic [ROM_AW-1:0] rom_idx;

   assign rom_idx  = ROM_AW'(tap_q);
   assign tap_coef = CW'(FILTER_COEF_ROM[rom_idx]);
`endif

   // Both operands sign-extended to the product width; DW+CW = PROD_W so the product is exact.
   assign tap_prod = PROD_W'(tap_sample) * PROD_W'(tap_coef);

   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      acc_enable_d = 1'b0;
      acc_load_d   = 1'b0;
      acc_d_d      = '0;
      case (state_q)
         ST_IDLE: begin
            if (sample_valid) begin
               state_d = ST_RUN;
               tap_d   = '0;
            end
         end
         ST_RUN: begin
            // Controls are registered with the product, so the accumulator sees them one cycle later.
            acc_enable_d = 1'b1;
            acc_load_d   = (tap_q == '0);
            acc_d_d      = tap_prod;
            if (tap_q == TAP_LAST) begin
               state_d = ST_DRAIN;
            end else begin
               tap_d = tap_q + AW'(1);
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q      <= ST_IDLE;
         tap_q        <= '0;
         acc_enable_q <= 1'b0;
         acc_load_q   <= 1'b0;
         acc_d_q      <= '0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         acc_enable_q <= acc_enable_d;
         acc_load_q   <= acc_load_d;
         acc_d_q      <= acc_d_d;
      end
   end

   assign sample_ready = (state_q == ST_IDLE);
   assign sum_valid    = (state_q == ST_DONE);
   assign acc_enable   = acc_enable_q;
   assign acc_load     = acc_load_q;
   assign acc_d        = acc_d_q;

endmodule

// File: doc/filter_mac_sequencer.md
FILTER_MAC_SEQUENCER -- requirements
Module: filter_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 16, tap count; power of two, 2..64.
REQ-002 SHALL have parameter DW, default 16, signed sample width.
REQ-003 SHALL have parameter CW, default 16, signed coefficient width; DW+CW SHALL equal 32.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rstb  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_valid  input  1  new input sample offered.
REQ-007 SHALL have port sample_data  input  DW  signed input sample.
REQ-008 SHALL have port sample_ready  output  1  high only in IDLE.
REQ-009 SHALL have port coef_we  input  1  coefficient write strobe (present only with FILTER_SEQ_COEF_WR_EN).
REQ-010 SHALL have port coef_addr  input  log2(NTAPS)  coefficient index (present only with FILTER_SEQ_COEF_WR_EN).
REQ-011 SHALL have port coef_data  input  CW  signed coefficient (present only with FILTER_SEQ_COEF_WR_EN).
REQ-012 SHALL have port acc_enable  output  1  drives downstream accumulator enable.
REQ-013 SHALL have port acc_load  output  1  drives accumulator load; high on first tap only.
REQ-014 SHALL have port acc_d  output  32  signed registered product to accumulator D input.
REQ-015 SHALL have port sum_valid  output  1  one-cycle pulse; accumulator output holds completed sum.

Function
REQ-016 SHALL accept a sample in cycle T when sample_valid and sample_ready are both high; sample_valid while busy SHALL be ignored and the sample dropped.
REQ-017 SHALL store accepted samples in an NTAPS-entry circular delay line; write pointer advances mod NTAPS per accept.
REQ-018 SHALL implement FSM IDLE -> RUN (exactly NTAPS cycles, T+1..T+NTAPS) -> DRAIN (T+NTAPS+1) -> DONE (T+NTAPS+2) -> IDLE; throughput one sample per NTAPS+3 cycles.
REQ-019 In RUN cycle for tap k (k=0..NTAPS-1), SHALL read coef[k] and sample at (newest - k) mod NTAPS, newest being the sample accepted at T.
REQ-020 SHALL register the full-precision signed product coef[k]*x[n-k] (32 bits, no rounding or saturation) onto acc_d one cycle after the read.
REQ-021 SHALL assert acc_enable in cycles T+2..T+NTAPS+1 only, with acc_load high in T+2 only.
REQ-022 SHALL pulse sum_valid in DONE (T+NTAPS+2), when the 41-bit accumulator output equals sum of all NTAPS products.
REQ-023 acc_d SHALL hold zero whenever acc_enable is low.
REQ-024 Taps referring to entries never written since reset SHALL contribute zero.

Reset
REQ-025 rstb high at any clock edge, including mid-RUN/DRAIN, SHALL force IDLE, sample_ready=1 the following cycle, acc_enable=0, acc_load=0, acc_d=0, sum_valid=0, write pointer=0, all delay-line entries=0; no sum_valid for the aborted sample.
REQ-026 With FILTER_SEQ_COEF_WR_EN, reset SHALL clear all coefficient registers to 0.

Configuration
REQ-027 With FILTER_SEQ_COEF_WR_EN defined, coefficients SHALL be a writable register file; coef_we honored only in IDLE, ignored in RUN/DRAIN/DONE, write visible to the next accepted sample.
REQ-028 Without FILTER_SEQ_COEF_WR_EN, coef_* ports SHALL be absent and coefficients SHALL be constants taken from the shared package table.

Structure
REQ-029 Shared package filter_pkg SHALL hold FSM state typedef, product width constant (32), accumulator width constant (41), and default coefficient table FILTER_COEF_ROM.
REQ-030 Delay line SHALL be one sub-module filter_delay_line (circular buffer, write port, one read port, synchronous clear).

Verification
REQ-031 Impulse: coefs 1..16 written, samples 1 then 15 zeros -> successive sums 1,2,...,16.
REQ-032 Extreme values: all coefs -32768, one sample -32768 -> acc_d 0x40000000 in T+2, sum after DONE 1073741824.
REQ-033 Wrap: all coefs 1, 17 samples of value 1 -> sums 1,2,...,16,16.
REQ-034 Busy drop: sample_valid held high continuously -> sample_ready low T+1..T+NTAPS+2, accepts spaced exactly 19 cycles (NTAPS=16).
REQ-035 Reset in RUN at T+5 -> acc_enable 0 next cycle, no sum_valid, next sample after reset yields sum of that sample times coef[0] only.
REQ-036 Macro off: impulse of 1 -> sums equal FILTER_COEF_ROM entries in order; coef_we ports absent at compile.
